// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the OBI-style data-memory interface.
// Carries the response record and the byte-enable-to-bit-mask expansion.
package mem_if_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int BE_WIDTH   = 4;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [WORD_WIDTH-1:0] rdata;
  } mem_rsp_t;

  function automatic logic [WORD_WIDTH-1:0] be_to_mask(input logic [BE_WIDTH-1:0] be);
    logic [WORD_WIDTH-1:0] mask;
    mask = '0;
    for (int b = 0; b < BE_WIDTH; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Contents are deliberately left unreset.
module sp_ram_be
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic [WORD_WIDTH-1:0] rdata_o
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_WIDTH-1:0] rdata_q;
  logic [WORD_WIDTH-1:0] mask;

  assign mask = be_to_mask(be_i);

  // The read register only moves on read accesses, so it stays stable between them.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= (mem_q[addr_i] & ~mask) | (wdata_i & mask);
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the core's data-memory bus: grant after programmable
// wait-states, then in-order responses after a fixed pipeline latency.
module data_mem_responder
  import mem_if_pkg::mem_rsp_t;
  import mem_if_pkg::BE_WIDTH;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int GNT_WAIT    = 0,
  parameter int RVALID_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic [WORD_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [WORD_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [WORD_WIDTH-1:0] data_rdata_o
);

  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int WCNT_W = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;

  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  gnt;
  logic [WORD_WIDTH-1:0] ram_rdata;
  logic [WORD_WIDTH-1:0] rdata_hold_q;
  mem_rsp_t              pipe_q [RVALID_LAT];
  mem_rsp_t              rsp0, rsp_out;
  logic                  unused_addr;

  assign unused_addr = ^{data_addr_i[WORD_WIDTH-1:AW+2], data_addr_i[1:0]};

  assign gnt        = data_req_i && rst_n && (wcnt_q == WCNT_W'(GNT_WAIT));
  assign data_gnt_o = gnt;

  // Counter restarts both on grant and when the requester gives up early.
  always_comb begin
    wcnt_d = '0;
    if (data_req_i && !gnt) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
  end

  sp_ram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .en_i    (gnt),
    .we_i    (data_we_i),
    .addr_i  (data_addr_i[AW+1:2]),
    .be_i    (data_be_i),
    .wdata_i (data_wdata_i),
    .rdata_o (ram_rdata)
  );

  // Stage 0 holds only valid/we; its data comes straight out of the RAM read register.
  always_comb begin
    rsp0       = pipe_q[0];
    rsp0.rdata = pipe_q[0].we ? '0 : ram_rdata;
  end

  assign rsp_out = (RVALID_LAT == 1) ? rsp0 : pipe_q[RVALID_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q       <= '0;
      rdata_hold_q <= '0;
      for (int i = 0; i < RVALID_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      wcnt_q    <= wcnt_d;
      pipe_q[0] <= '{valid: gnt, we: gnt & data_we_i, rdata: '0};
      for (int i = 1; i < RVALID_LAT; i++) begin
        pipe_q[i] <= (i == 1) ? rsp0 : pipe_q[i-1];
      end
      if (rsp_out.valid) begin
        rdata_hold_q <= rsp_out.rdata;
      end
    end
  end

  assign data_rvalid_o = rsp_out.valid;
  assign data_rdata_o  = rsp_out.valid ? rsp_out.rdata : rdata_hold_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders with different wait/latency settings,
// expectations queued at grant and retired when rvalid appears.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN   [3];
  logic        req    [3];
  logic [31:0] addr   [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int latOf  [3] = '{1, 1, 3};
  int waitOf [3] = '{0, 2, 0};

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sbq [3][$];
  logic [31:0] model [16];

  data_mem_responder #(.GNT_WAIT(0), .RVALID_LAT(1)) u_a (
    .clk(clk), .rst_n(rstN[0]), .data_req_i(req[0]), .data_addr_i(addr[0]),
    .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
    .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]));

  data_mem_responder #(.GNT_WAIT(2), .RVALID_LAT(1)) u_b (
    .clk(clk), .rst_n(rstN[1]), .data_req_i(req[1]), .data_addr_i(addr[1]),
    .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
    .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]));

  data_mem_responder #(.GNT_WAIT(0), .RVALID_LAT(3)) u_c (
    .clk(clk), .rst_n(rstN[2]), .data_req_i(req[2]), .data_addr_i(addr[2]),
    .data_we_i(we[2]), .data_be_i(be[2]), .data_wdata_i(wdata[2]),
    .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Retire expectations in order; flag early, late, missing and stray responses.
  for (genvar k = 0; k < 3; k++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      if (rvalid[k] === 1'b1) begin
        if (sbq[k].size() == 0) begin
          checkOutput($sformatf("stray_rvalid%0d", k), 32'd1, 32'd0);
        end else begin
          e = sbq[k].pop_front();
          checkOutput($sformatf("rdata%0d", k), rdata[k], e.data);
          checkOutput($sformatf("rvalid_cycle%0d", k), cyc, e.due);
        end
      end else if (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
        e = sbq[k].pop_front();
        checkOutput($sformatf("rvalid_missing%0d", k), 32'd0, 32'd1);
      end
    end
  end

  task automatic applyStimulus(input int sel, input logic wr, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] wd,
                               input logic [31:0] expData, input bit push);
    int waited = 0;
    bit got    = 0;
    exp_t e;
    req[sel]   = 1'b1;
    we[sel]    = wr;
    addr[sel]  = a;
    be[sel]    = b;
    wdata[sel] = wd;
    while (!got && waited < 20) begin
      @(negedge clk);
      if (gnt[sel] === 1'b1) got = 1;
      else waited++;
    end
    if (got) begin
      checkOutput($sformatf("gnt_wait%0d", sel), waited, waitOf[sel]);
      if (push) begin
        e.data = expData;
        e.due  = cyc + latOf[sel];
        sbq[sel].push_back(e);
      end
    end else begin
      checkOutput($sformatf("gnt_timeout%0d", sel), 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int sel, input int n);
    req[sel] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      rstN[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0;
      addr[k] = '0; be[k] = '0; wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst_gnt%0d", k), gnt[k], 32'd0);
      checkOutput($sformatf("rst_rvalid%0d", k), rvalid[k], 32'd0);
      checkOutput($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rstN[k] = 1'b1;
    @(posedge clk); #1;

    // Instance A: basic write/read, byte enables, aliasing, hold behaviour.
    applyStimulus(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1);
    applyStimulus(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1);
    idle(0, 2);
    applyStimulus(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1);
    applyStimulus(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1);
    applyStimulus(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1);
    idle(0, 2);
    applyStimulus(0, 1'b1, 32'h1004, 4'hF, 32'h5A5A5A5A, 32'h0, 1);
    applyStimulus(0, 1'b0, 32'h0004, 4'hF, 32'h0, 32'h5A5A5A5A, 1);
    applyStimulus(0, 1'b1, 32'h2006, 4'b0010, 32'h00007700, 32'h0, 1);
    applyStimulus(0, 1'b0, 32'h0004, 4'hF, 32'h0, 32'h5A5A775A, 1);
    idle(0, 3);
    @(negedge clk);
    checkOutput("hold_rdata", rdata[0], 32'h5A5A775A);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 32'h30, 4'hF, 32'h12345678, 32'h0, 1);
    idle(0, 2);
    @(negedge clk);
    checkOutput("rdata_after_write", rdata[0], 32'h0);
    @(posedge clk); #1;

    // Instance B: wait-states and an abandoned request.
    applyStimulus(1, 1'b1, 32'h40, 4'hF, 32'h0BADF00D, 32'h0, 1);
    idle(1, 1);
    applyStimulus(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h0BADF00D, 1);
    idle(1, 2);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40;
    @(negedge clk);
    checkOutput("drop_c0_gnt", gnt[1], 32'd0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("drop_gnt", gnt[1], 32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 32'h44, 4'hF, 32'h00C0FFEE, 32'h0, 1);
    applyStimulus(1, 1'b0, 32'h44, 4'hF, 32'h0, 32'h00C0FFEE, 1);
    idle(1, 3);

    // Instance C: deep pipeline, back-to-back, reset with responses in flight.
    for (int i = 0; i < 4; i++)
      applyStimulus(2, 1'b1, 32'(4*i), 4'hF, 32'(i+1), 32'h0, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus(2, 1'b0, 32'(4*i), 4'hF, 32'h0, 32'(i+1), 1);
    applyStimulus(2, 1'b1, 32'h50, 4'hF, 32'hCAFE0001, 32'h0, 1);
    applyStimulus(2, 1'b0, 32'h50, 4'hF, 32'h0, 32'hCAFE0001, 1);
    idle(2, 6);
    applyStimulus(2, 1'b0, 32'h8, 4'hF, 32'h0, 32'h0, 0);
    req[2]  = 1'b0;
    rstN[2] = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rvalid", rvalid[2], 32'd0);
    checkOutput("midrst_rdata", rdata[2], 32'd0);
    @(posedge clk); #1;
    rstN[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("postrst_rvalid", rvalid[2], 32'd0);
      checkOutput("postrst_rdata", rdata[2], 32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(2, 1'b0, 32'h50, 4'hF, 32'h0, 32'hCAFE0001, 1);
    idle(2, 6);

    // Instance A: random back-to-back traffic against a small word model.
    for (int w = 0; w < 16; w++) begin
      model[w] = $urandom;
      applyStimulus(0, 1'b1, 32'(4*w), 4'hF, model[w], 32'h0, 1);
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, wd;
      logic [3:0]  b;
      logic [3:0]  w;
      logic        wr;
      w  = 4'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      b  = 4'($urandom_range(0, 15));
      wd = $urandom;
      a  = {18'($urandom), 6'd0, w, 2'($urandom_range(0, 3))};
      if (wr) begin
        model[w] = merge(model[w], wd, b);
        applyStimulus(0, 1'b1, a, b, wd, 32'h0, 1);
      end else begin
        applyStimulus(0, 1'b0, a, b, wd, model[w], 1);
      end
    end
    idle(0, 6);

    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("sb_empty%0d", k), sbq[k].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
